tcdm_pipe_req: RTL

TCDM_PIPE_REQ -- requirements
Module: tcdm_pipe_req

---
 rtl/tcdm_pkg.sv | 24 ++
 rtl/tcdm_pipe_req_slot.sv | 28 ++
 rtl/tcdm_pipe_req.sv | 106 ++++++++++
 3 files changed

// File: rtl/tcdm_pkg.sv
// tcdm_pkg: shared buffer state encoding and default request payload layout.
//   tcdm_state_e : occupancy of the 2-entry request skid buffer
//   tcdm_req_t   : request payload (add, wen, wdata, be) at the default widths,
//                  used as the default payload type of tcdm_pipe_req_slot
package tcdm_pkg;

    localparam int unsigned TCDM_ADDR_WIDTH = 32;
    localparam int unsigned TCDM_DATA_WIDTH = 32;
    localparam int unsigned TCDM_BE_WIDTH   = TCDM_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } tcdm_state_e;

    typedef struct packed {
        logic [TCDM_ADDR_WIDTH-1:0] add;
        logic                       wen;
        logic [TCDM_DATA_WIDTH-1:0] wdata;
        logic [TCDM_BE_WIDTH-1:0]   be;
    } tcdm_req_t;

endpackage

// File: rtl/tcdm_pipe_req_slot.sv
// tcdm_pipe_req_slot: load-enabled payload register with asynchronous clear.
//   clk_i  : clock
//   rstn_i : asynchronous active-low clear
//   load_i : capture d_i on the next rising edge
//   d_i    : payload in
//   q_o    : stored payload
module tcdm_pipe_req_slot
    import tcdm_pkg::*;
#(
    parameter type T = tcdm_req_t
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic load_i,
    input  T     d_i,
    output T     q_o
);

    T slot_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) slot_q <= '0;
        else if (load_i) slot_q <= d_i;
    end

    assign q_o = slot_q;

endmodule

// File: rtl/tcdm_pipe_req.sv
// tcdm_pipe_req: 2-entry in-order request pipe stage between an initiator and an SRAM bank.
//   clk_i, rstn_i                 : clock, asynchronous active-low reset
//   data_req_i .. data_be_i       : initiator request (valid + payload)
//   data_gnt_o                    : grant to initiator, decoded from state only
//   data_*_SRAM_o                 : registered request toward the bank (payload zero when idle)
//   data_gnt_SRAM_i               : bank grant
//   rvalid_o                      : read-data-valid, one cycle after a read is issued
module tcdm_pipe_req
    import tcdm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_add_i,
    input  logic                  data_wen_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    input  logic [BE_WIDTH-1:0]   data_be_i,
    output logic                  data_gnt_o,
    output logic                  data_req_SRAM_o,
    output logic [ADDR_WIDTH-1:0] data_add_SRAM_o,
    output logic                  data_wen_SRAM_o,
    output logic [DATA_WIDTH-1:0] data_wdata_SRAM_o,
    output logic [BE_WIDTH-1:0]   data_be_SRAM_o,
    input  logic                  data_gnt_SRAM_i,
    output logic                  rvalid_o
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] add;
        logic                  wen;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_WIDTH-1:0]   be;
    } req_t;

    tcdm_state_e state_q, state_d;
    req_t        in_req, head_q, skid_q, head_d;
    logic        head_ld, skid_ld, accept, issue, rvalid_q;

    assign in_req          = '{add: data_add_i, wen: data_wen_i, wdata: data_wdata_i, be: data_be_i};
    assign data_gnt_o      = state_q != FULL;
    assign data_req_SRAM_o = state_q != EMPTY;
    assign accept          = data_req_i & data_gnt_o;
    assign issue           = data_req_SRAM_o & data_gnt_SRAM_i;

    // Draining FULL promotes the skid entry; every other head load takes the new request.
    assign head_d = state_q == FULL ? skid_q : in_req;

    always_comb begin
        state_d = state_q;
        head_ld = 1'b0;
        skid_ld = 1'b0;
        case (state_q)
            EMPTY: begin
                head_ld = accept;
                state_d = accept ? ONE : EMPTY;
            end
            ONE: begin
                head_ld = accept & issue;
                skid_ld = accept & ~issue;
                state_d = skid_ld ? FULL : (issue & ~accept) ? EMPTY : ONE;
            end
            FULL: begin
                head_ld = issue;
                state_d = issue ? ONE : FULL;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= EMPTY;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= issue & head_q.wen;
        end
    end

    tcdm_pipe_req_slot #(.T(req_t)) i_head (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .load_i (head_ld),
        .d_i    (head_d),
        .q_o    (head_q)
    );

    tcdm_pipe_req_slot #(.T(req_t)) i_skid (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .load_i (skid_ld),
        .d_i    (in_req),
        .q_o    (skid_q)
    );

    assign data_add_SRAM_o   = data_req_SRAM_o ? head_q.add   : '0;
    assign data_wen_SRAM_o   = data_req_SRAM_o ? head_q.wen   : 1'b0;
    assign data_wdata_SRAM_o = data_req_SRAM_o ? head_q.wdata : '0;
    assign data_be_SRAM_o    = data_req_SRAM_o ? head_q.be    : '0;
    assign rvalid_o          = rvalid_q;

endmodule
